// File: rtl/instr_queue_pkg.sv
// Shared types for the fetch-to-dispatch instruction queue.
// Combinational only: types and constants, no state.
// No flow control of its own.
package instr_queue_pkg;

  typedef logic [31:0] word_t;
  typedef logic [13:0] pc_t;

  // One queued fetch result: instruction word, its PC and the predicted next PC.
  typedef struct packed {
    word_t instr;
    pc_t   PC;
    pc_t   nPC;
  } iq_entry_t;

  localparam int IQ_DEPTH_DEFAULT = 8;
  localparam int IQ_SKID_DEFAULT  = 2;

endpackage

// File: rtl/instr_queue_if.sv
// Fetch-side and dispatch-side signal bundle of the instruction queue.
// No logic; the slave modport is the queue, the master modport its environment.
// Backpressure: fetch_stall toward fetch, dispatch_ready from the consumer.
interface instr_queue_if #(
  parameter int DEPTH = 8
) ();
  import instr_queue_pkg::*;

  localparam int LOG_DEPTH = $clog2(DEPTH);

  // fetch side
  logic  fetch_ivalid;
  word_t fetch_instr;
  pc_t   fetch_PC;
  pc_t   fetch_nPC;
  logic  fetch_stall;

  // pipeline redirect
  logic  flush;

  // dispatch side
  logic  dispatch_valid;
  logic  dispatch_ready;
  word_t dispatch_instr;
  pc_t   dispatch_PC;
  pc_t   dispatch_nPC;

  // status
  logic [LOG_DEPTH:0] count;
  logic               overflow_err;

  modport master (
    output fetch_ivalid, fetch_instr, fetch_PC, fetch_nPC, flush, dispatch_ready,
    input  fetch_stall, dispatch_valid, dispatch_instr, dispatch_PC, dispatch_nPC,
    input  count, overflow_err
  );

  modport slave (
    input  fetch_ivalid, fetch_instr, fetch_PC, fetch_nPC, flush, dispatch_ready,
    output fetch_stall, dispatch_valid, dispatch_instr, dispatch_PC, dispatch_nPC,
    output count, overflow_err
  );

endinterface

// File: rtl/instr_queue.sv
// Decoupling FIFO between fetch and decode/dispatch, flushed on a resolved redirect.
// Latency: an enqueued entry is visible at dispatch one cycle later (no bypass).
// Backpressure: fetch_stall raised at DEPTH-SKID entries so in-flight fetches still land.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT,
  parameter int SKID  = IQ_SKID_DEFAULT
) (
  input logic         CLK,
  input logic         RST,
  instr_queue_if.slave iq
);

  localparam int LOG_DEPTH = $clog2(DEPTH);

  typedef logic [LOG_DEPTH:0]   ptr_t;
  typedef logic [LOG_DEPTH-1:0] idx_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam ptr_t STALL_AT = ptr_t'(DEPTH - SKID);

  // Parameter sanity at elaboration time.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_queue: DEPTH must be a power of two and at least 4");
  end
  if (SKID >= DEPTH) begin : g_bad_skid
    $error("instr_queue: SKID must be smaller than DEPTH");
  end

  ptr_t      rd_ptr_q, rd_ptr_d;
  ptr_t      wr_ptr_q, wr_ptr_d;
  ptr_t      count_q,  count_d;
  logic      ovf_q,    ovf_d;
  iq_entry_t mem_q [DEPTH];

  logic      empty;
  logic      full;
  logic      deq;
  logic      enq;
  logic      drop;
  iq_entry_t wr_entry;
  iq_entry_t head;

  // The extra pointer MSB separates the full case from the empty case.
  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[LOG_DEPTH-1:0] == wr_ptr_q[LOG_DEPTH-1:0]) &&
                 (rd_ptr_q[LOG_DEPTH] != wr_ptr_q[LOG_DEPTH]);

  // A flush cancels both the dispatch handshake and the wrong-path fetch.
  assign deq  = ~empty & iq.dispatch_ready & ~iq.flush;
  assign enq  = iq.fetch_ivalid & ~iq.flush & (~full | deq);
  assign drop = iq.fetch_ivalid & ~iq.flush & full & ~deq;

  assign wr_entry = '{instr: iq.fetch_instr, PC: iq.fetch_PC, nPC: iq.fetch_nPC};
  assign head     = mem_q[idx_t'(rd_ptr_q[LOG_DEPTH-1:0])];

  assign iq.dispatch_valid = ~empty;
  assign iq.dispatch_instr = head.instr;
  assign iq.dispatch_PC    = head.PC;
  assign iq.dispatch_nPC   = head.nPC;
  assign iq.count          = count_q;
  assign iq.overflow_err   = ovf_q;

  // Stall from the registered occupancy so fetch sees it early enough to
  // cover its registered icache read enable plus the response in flight.
  assign iq.fetch_stall = (count_q >= STALL_AT);

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | drop;
    if (iq.flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      count_d = count_q + (enq ? PTR_ONE : '0) - (deq ? PTR_ONE : '0);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge CLK) begin
    if (!RST && enq) begin
      mem_q[idx_t'(wr_ptr_q[LOG_DEPTH-1:0])] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Randomized and directed bench for instr_queue with a queue-based reference model.
module tb_instr_queue;
  import instr_queue_pkg::*;

  localparam int D = 8;
  localparam int S = 2;

  logic CLK;
  logic RST;

  instr_queue_if #(.DEPTH(D)) iq ();

  instr_queue #(.DEPTH(D), .SKID(S)) dut (
    .CLK (CLK),
    .RST (RST),
    .iq  (iq.slave)
  );

  int checks = 0;
  int errors = 0;

  iq_entry_t exp_q[$];
  logic      exp_ovf = 1'b0;
  logic      stream_on = 1'b0;
  pc_t       seen_pcs[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + reference model: compare at the falling edge, then advance the
  // model by the transaction the upcoming rising edge will perform.
  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      chk("count", 64'(iq.count), 64'(exp_q.size()));
      chk("dispatch_valid", 64'(iq.dispatch_valid), 64'(exp_q.size() != 0));
      chk("fetch_stall", 64'(iq.fetch_stall), 64'(exp_q.size() >= D - S));
      chk("overflow_err", 64'(iq.overflow_err), 64'(exp_ovf));
      if (exp_q.size() != 0) begin
        chk("dispatch_instr", 64'(iq.dispatch_instr), 64'(exp_q[0].instr));
        chk("dispatch_PC", 64'(iq.dispatch_PC), 64'(exp_q[0].PC));
        chk("dispatch_nPC", 64'(iq.dispatch_nPC), 64'(exp_q[0].nPC));
      end
      if (iq.flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && iq.dispatch_ready) begin
          if (stream_on) seen_pcs.push_back(exp_q[0].PC);
          void'(exp_q.pop_front());
        end
        if (iq.fetch_ivalid) begin
          if (exp_q.size() < D)
            exp_q.push_back('{instr: iq.fetch_instr, PC: iq.fetch_PC, nPC: iq.fetch_nPC});
          else
            exp_ovf = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic iv, input word_t ins, input pc_t pc, input pc_t npc,
                       input logic rdy, input logic fl);
    iq.fetch_ivalid   = iv;
    iq.fetch_instr    = ins;
    iq.fetch_PC       = pc;
    iq.fetch_nPC      = npc;
    iq.dispatch_ready = rdy;
    iq.flush          = fl;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    repeat (3) step();
    chk("rst_count", 64'(iq.count), 64'd0);
    chk("rst_valid", 64'(iq.dispatch_valid), 64'd0);
    chk("rst_stall", 64'(iq.fetch_stall), 64'd0);
    chk("rst_ovf", 64'(iq.overflow_err), 64'd0);
    RST = 1'b0;
  endtask

  // Global time bound.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic s1, s2, iv, rdy, fl;
    int   next_pc, budget;

    RST = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    do_reset();

    // First enqueue becomes visible the following cycle.
    drive(1'b1, 32'h2001_0004, 14'h010, 14'h011, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("first_valid", 64'(iq.dispatch_valid), 64'd1);
    chk("first_instr", 64'(iq.dispatch_instr), 64'h2001_0004);
    chk("first_PC", 64'(iq.dispatch_PC), 64'h010);
    chk("first_nPC", 64'(iq.dispatch_nPC), 64'h011);
    chk("first_count", 64'(iq.count), 64'd1);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();
    chk("drain_count", 64'(iq.count), 64'd0);

    // Fill to DEPTH with the consumer stalled.
    for (int i = 0; i < D; i++) begin
      drive(1'b1, 32'hA000_0000 + 32'(i), 14'(16'h100 + i), 14'(16'h101 + i), 1'b0, 1'b0);
      step();
      if (i == 4) chk("stall_at5", 64'(iq.fetch_stall), 64'd0);
      if (i == 5) begin
        chk("count_at6", 64'(iq.count), 64'd6);
        chk("stall_at6", 64'(iq.fetch_stall), 64'd1);
      end
    end
    chk("full_count", 64'(iq.count), 64'd8);
    chk("full_ovf", 64'(iq.overflow_err), 64'd0);

    // Full with a simultaneous dequeue: accepted, count holds.
    drive(1'b1, 32'hA000_0008, 14'h108, 14'h109, 1'b1, 1'b0);
    step();
    chk("fulldeq_count", 64'(iq.count), 64'd8);
    chk("fulldeq_head", 64'(iq.dispatch_PC), 64'h101);

    // Full without a dequeue: dropped, sticky error.
    drive(1'b1, 32'hDEAD_BEEF, 14'h3FF, 14'h3FF, 1'b0, 1'b0);
    step();
    chk("drop_count", 64'(iq.count), 64'd8);
    chk("drop_ovf", 64'(iq.overflow_err), 64'd1);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    repeat (3) step();
    chk("ovf_sticky", 64'(iq.overflow_err), 64'd1);
    do_reset();

    // Flush with 5 entries, a wrong-path fetch and a dispatch handshake.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hB000_0000 + 32'(i), 14'(16'h200 + i), 14'(16'h201 + i), 1'b0, 1'b0);
      step();
    end
    chk("preflush_count", 64'(iq.count), 64'd5);
    drive(1'b1, 32'hBAD0_0000, 14'h2FF, 14'h2FF, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("flush_count", 64'(iq.count), 64'd0);
    chk("flush_valid", 64'(iq.dispatch_valid), 64'd0);
    chk("flush_stall", 64'(iq.fetch_stall), 64'd0);

    // Stream PCs 0..19 with a fetch that reacts to stall two cycles late.
    stream_on = 1'b1;
    seen_pcs.delete();
    next_pc = 0;
    s1 = 1'b0;
    s2 = 1'b0;
    budget = 0;
    while ((next_pc < 20 || iq.count != 0) && budget < 400) begin
      iv  = (next_pc < 20) && !s2 && ($urandom_range(3) != 0);
      rdy = ($urandom_range(1) == 1) || (next_pc >= 20);
      drive(iv, 32'hC000_0000 + 32'(next_pc), 14'(next_pc), 14'(next_pc + 1), rdy, 1'b0);
      if (iv) next_pc++;
      s2 = s1;
      s1 = iq.fetch_stall;
      step();
      // fetch_stall sampled after this edge feeds the history
      budget++;
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    stream_on = 1'b0;
    chk("stream_done", 64'(budget < 400), 64'd1);
    chk("stream_len", 64'(seen_pcs.size()), 64'd20);
    for (int i = 0; i < 20 && i < seen_pcs.size(); i++)
      chk("stream_order", 64'(seen_pcs[i]), 64'(i));
    chk("stream_ovf", 64'(iq.overflow_err), 64'd0);

    // Random traffic with occasional redirects.
    s1 = 1'b0;
    s2 = 1'b0;
    for (int c = 0; c < 500; c++) begin
      iv  = !s2 && ($urandom_range(4) != 0);
      rdy = ($urandom_range(2) != 0);
      fl  = ($urandom_range(39) == 0);
      drive(iv, word_t'($urandom), pc_t'($urandom), pc_t'($urandom), rdy, fl);
      s2 = s1;
      s1 = iq.fetch_stall;
      step();
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    chk("random_ovf", 64'(iq.overflow_err), 64'd0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
